// File: rtl/rtp_pkg.sv
// Shared types for the ray hit collector.
// Holds FSM state, miss marker and the result record.
package rtp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_DONE
  } rtp_state_e;

  localparam logic [31:0] MISS_HITT = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] ray_id;
    logic [31:0] hitT;
    logic [31:0] tri_idx;
  } rtp_rec_t;

endpackage

// File: rtl/rtp_result_fifo.sv
// Small synchronous FIFO of result records.
// Flush drops all entries; head is visible while not empty.
module rtp_result_fifo
  import rtp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush_i,
  input  logic     push_i,
  input  rtp_rec_t data_i,
  input  logic     pop_i,
  output rtp_rec_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(DEPTH);

  rtp_rec_t   mem_q [DEPTH];
  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rtp_hit_collector.sv
// Collects per-ray closest-hit results into frame RAMs.
// Counts stored rays and misses, flags duplicates and bad ids.
module rtp_hit_collector
  import rtp_pkg::*;
#(
  parameter  int NUM_RAYS   = 1024,
  parameter  int FIFO_DEPTH = 8,
  localparam int AW         = $clog2(NUM_RAYS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_ray_id,
  input  logic [31:0]   in_hitT,
  input  logic [31:0]   in_tri_idx,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_hitT,
  output logic [31:0]   rd_tri_idx,
  output logic [AW:0]   rays_done,
  output logic [AW:0]   miss_count,
  output logic          done,
  output logic          err_dup,
  output logic          err_range
);

  localparam logic [31:0]   NR32   = 32'(NUM_RAYS);
  localparam logic [AW-1:0] LAST   = AW'(NUM_RAYS - 1);
  localparam logic [AW:0]   NR_CNT = (AW+1)'(NUM_RAYS);

  rtp_state_e    state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [AW:0]   rays_q, rays_d;
  logic [AW:0]   miss_q, miss_d;
  logic          dup_q, dup_d;
  logic          rng_q, rng_d;

  logic [NUM_RAYS-1:0] flags_q;
  logic [31:0]         hit_mem [NUM_RAYS];
  logic [31:0]         tri_mem [NUM_RAYS];
  logic [31:0]         rd_hit_q;
  logic [31:0]         rd_tri_q;

  rtp_rec_t      in_rec;
  rtp_rec_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_flush;
  logic          fifo_pop;
  logic          clr_en;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic          in_range;

  assign in_rec   = '{ray_id: in_ray_id, hitT: in_hitT,
                      tri_idx: in_tri_idx};
  assign in_ready = (state_q == S_COLLECT) && !fifo_full;
  assign idx      = head.ray_id[AW-1:0];
  assign in_range = head.ray_id < NR32;

  rtp_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (in_valid && in_ready),
    .data_i  (in_rec),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    rays_d     = rays_q;
    miss_d     = miss_q;
    dup_d      = dup_q;
    rng_d      = rng_q;
    fifo_flush = 1'b0;
    fifo_pop   = 1'b0;
    clr_en     = 1'b0;
    wr_en      = 1'b0;
    // start from any state restarts the frame from a clean slate
    if (start) begin
      state_d    = S_CLEAR;
      clr_d      = '0;
      rays_d     = '0;
      miss_d     = '0;
      dup_d      = 1'b0;
      rng_d      = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_CLEAR: begin
          clr_en = 1'b1;
          clr_d  = clr_q + 1'b1;
          if (clr_q == LAST) state_d = S_COLLECT;
        end
        S_COLLECT: begin
          if (rays_q == NR_CNT) state_d = S_DONE;
          fifo_pop = !fifo_empty;
          if (fifo_pop) begin
            if (!in_range) begin
              rng_d = 1'b1;
            end else if (flags_q[idx]) begin
              dup_d = 1'b1;
            end else begin
              wr_en  = 1'b1;
              rays_d = rays_q + 1'b1;
              if (head.hitT == MISS_HITT) miss_d = miss_q + 1'b1;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      rays_q  <= '0;
      miss_q  <= '0;
      dup_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      rays_q  <= rays_d;
      miss_q  <= miss_d;
      dup_q   <= dup_d;
      rng_q   <= rng_d;
    end
  end

  always_ff @(posedge clock) begin
    if (clr_en)     flags_q[clr_q] <= 1'b0;
    else if (wr_en) flags_q[idx]   <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      hit_mem[idx] <= head.hitT;
      tri_mem[idx] <= head.tri_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_hit_q <= '0;
      rd_tri_q <= '0;
    end else begin
      rd_hit_q <= hit_mem[rd_addr];
      rd_tri_q <= tri_mem[rd_addr];
    end
  end

  assign rd_hitT    = rd_hit_q;
  assign rd_tri_idx = rd_tri_q;
  assign rays_done  = rays_q;
  assign miss_count = miss_q;
  assign done       = (state_q == S_DONE);
  assign err_dup    = dup_q;
  assign err_range  = rng_q;

endmodule

// File: tb/tb_rtp_hit_collector.sv
// Randomized bench for rtp_hit_collector (4 rays, 2-entry FIFO).
// Reference model applies the storage rules to each accepted record.
module tb_rtp_hit_collector;

  localparam logic [31:0] MISS = 32'h7F80_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ray_id;
  logic [31:0] in_hitT;
  logic [31:0] in_tri_idx;
  logic [1:0]  rd_addr;
  logic [31:0] rd_hitT;
  logic [31:0] rd_tri_idx;
  logic [2:0]  rays_done;
  logic [2:0]  miss_count;
  logic        done;
  logic        err_dup;
  logic        err_range;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hit [4];
  logic [31:0] m_tri [4];
  bit          m_wr  [4];
  int          m_done;
  int          m_miss;
  bit          m_dup;
  bit          m_rng;

  rtp_hit_collector #(
    .NUM_RAYS   (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ray_id  (in_ray_id),
    .in_hitT    (in_hitT),
    .in_tri_idx (in_tri_idx),
    .rd_addr    (rd_addr),
    .rd_hitT    (rd_hitT),
    .rd_tri_idx (rd_tri_idx),
    .rays_done  (rays_done),
    .miss_count (miss_count),
    .done       (done),
    .err_dup    (err_dup),
    .err_range  (err_range)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_apply(input logic [31:0] id,
                             input logic [31:0] h,
                             input logic [31:0] t);
    if (id >= 4) begin
      m_rng = 1'b1;
    end else if (m_wr[id[1:0]]) begin
      m_dup = 1'b1;
    end else begin
      m_wr[id[1:0]]  = 1'b1;
      m_hit[id[1:0]] = h;
      m_tri[id[1:0]] = t;
      m_done++;
      if (h == MISS) m_miss++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_wr[i] = 1'b0;
    m_done = 0;
    m_miss = 0;
    m_dup  = 1'b0;
    m_rng  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_done = 0;
    m_miss = 0;
    m_dup  = 1'b0;
    m_rng  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_collect();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 40);
    @(posedge clock);
    #1;
    checks++;
    if (!in_ready) begin
      $display("FAIL wait_collect in_ready=%b required=1", in_ready);
      failures++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 60);
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL wait_done done=%b required=1", done);
      failures++;
    end
  endtask

  task automatic send(input logic [31:0] id, input logic [31:0] h,
                      input logic [31:0] t, input bit keep,
                      output int stalls);
    logic rdy;
    in_valid   = 1'b1;
    in_ray_id  = id;
    in_hitT    = h;
    in_tri_idx = t;
    stalls     = 0;
    while (1) begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      #1;
      if (rdy) begin
        model_apply(id, h, t);
        break;
      end
      stalls++;
      if (stalls > 40) begin
        checks++;
        failures++;
        $display("FAIL send_timeout id=%0d in_ready=%b required=1",
                 id, in_ready);
        break;
      end
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic read_port(input logic [1:0] a,
                           output logic [31:0] h,
                           output logic [31:0] t);
    rd_addr = a;
    @(posedge clock);
    @(negedge clock);
    h = rd_hitT;
    t = rd_tri_idx;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    start    = 1'b1;
    reset    = 1'b1;
    rd_addr  = 2'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({in_ready, done, err_dup, err_range} !== 4'b0) begin
      $display("FAIL reset_flags rdy/done/dup/rng=%b required=0000",
               {in_ready, done, err_dup, err_range});
      failures++;
    end
    checks++;
    if (rays_done !== 3'd0 || miss_count !== 3'd0) begin
      $display("FAIL reset_counts rays=%0d miss=%0d required=0/0",
               rays_done, miss_count);
      failures++;
    end
    checks++;
    if (rd_hitT !== 32'd0 || rd_tri_idx !== 32'd0) begin
      $display("FAIL reset_rd hit=%h tri=%h required=0/0",
               rd_hitT, rd_tri_idx);
      failures++;
    end
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_idle in_ready=%b required=0", in_ready);
      failures++;
    end
  endtask

  task automatic test_clear_timing();
    do_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL clear_cycle%0d in_ready=%b required=0", i, in_ready);
        failures++;
      end
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL clear_end in_ready=%b required=1", in_ready);
      failures++;
    end
    checks++;
    if (rays_done !== 3'd0) begin
      $display("FAIL clear_rays rays_done=%0d required=0", rays_done);
      failures++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_frame();
    logic [31:0] ids [4];
    logic [31:0] hs  [4];
    logic [31:0] h, t;
    int st;
    ids = '{32'd3, 32'd0, 32'd2, 32'd1};
    hs  = '{32'h3F80_0000, MISS, 32'h4000_0000, 32'h3F00_0000};
    for (int i = 0; i < 4; i++) send(ids[i], hs[i], $urandom, 1'b0, st);
    wait_done();
    checks++;
    if (rays_done !== 3'(m_done) || miss_count !== 3'(m_miss)) begin
      $display("FAIL frame_counts rays=%0d miss=%0d required=%0d/%0d",
               rays_done, miss_count, m_done, m_miss);
      failures++;
    end
    checks++;
    if (miss_count !== 3'd1) begin
      $display("FAIL frame_miss miss=%0d required=1", miss_count);
      failures++;
    end
    read_port(2'd2, h, t);
    checks++;
    if (h !== 32'h4000_0000 || t !== m_tri[2]) begin
      $display("FAIL frame_rd2 hit=%h tri=%h required=40000000/%h",
               h, t, m_tri[2]);
      failures++;
    end
    for (int a = 0; a < 4; a++) begin
      read_port(2'(a), h, t);
      checks++;
      if (h !== m_hit[a] || t !== m_tri[a]) begin
        $display("FAIL frame_rd addr=%0d hit=%h tri=%h required=%h/%h",
                 a, h, t, m_hit[a], m_tri[a]);
        failures++;
      end
    end
  endtask

  task automatic test_dup_range();
    logic [31:0] h, t, old3;
    int st;
    do_start();
    wait_collect();
    send(32'd1, 32'h4120_0000, 32'd11, 1'b0, st);
    send(32'd1, 32'h4130_0000, 32'd22, 1'b0, st);
    idle(3);
    checks++;
    if (err_dup !== 1'b1 || rays_done !== 3'd1) begin
      $display("FAIL dup err_dup=%b rays=%0d required=1/1",
               err_dup, rays_done);
      failures++;
    end
    read_port(2'd1, h, t);
    checks++;
    if (h !== 32'h4120_0000 || t !== 32'd11) begin
      $display("FAIL dup_keep hit=%h tri=%0d required=41200000/11", h, t);
      failures++;
    end
    old3 = m_hit[3];
    send(32'd7, 32'h1234_5678, 32'd99, 1'b0, st);
    idle(3);
    checks++;
    if (err_range !== 1'b1 || rays_done !== 3'd1) begin
      $display("FAIL range err_range=%b rays=%0d required=1/1",
               err_range, rays_done);
      failures++;
    end
    read_port(2'd3, h, t);
    checks++;
    if (h !== old3) begin
      $display("FAIL range_nowrite hit=%h required=%h", h, old3);
      failures++;
    end
    send(32'd0, MISS, $urandom, 1'b0, st);
    send(32'd2, $urandom, $urandom, 1'b0, st);
    send(32'd3, MISS, $urandom, 1'b0, st);
    wait_done();
    checks++;
    if (rays_done !== 3'(m_done) || miss_count !== 3'(m_miss) ||
        err_dup !== m_dup || err_range !== m_rng) begin
      $display("FAIL dup_frame rays=%0d miss=%0d dup=%b rng=%b required=%0d/%0d/%b/%b",
               rays_done, miss_count, err_dup, err_range,
               m_done, m_miss, m_dup, m_rng);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ids [3];
    logic [31:0] h, t;
    int st;
    ids = '{32'd0, 32'd0, 32'd1};
    do_start();
    wait_collect();
    for (int i = 0; i < 3; i++) begin
      send(ids[i], $urandom, $urandom, (i < 2), st);
      checks++;
      if (st != 0) begin
        $display("FAIL b2b_stall rec=%0d stalls=%0d required=0", i, st);
        failures++;
      end
    end
    idle(3);
    checks++;
    if (rays_done !== 3'd2 || err_dup !== 1'b1) begin
      $display("FAIL b2b_counts rays=%0d dup=%b required=2/1",
               rays_done, err_dup);
      failures++;
    end
    for (int a = 0; a < 2; a++) begin
      read_port(2'(a), h, t);
      checks++;
      if (h !== m_hit[a] || t !== m_tri[a]) begin
        $display("FAIL b2b_order addr=%0d hit=%h tri=%h required=%h/%h",
                 a, h, t, m_hit[a], m_tri[a]);
        failures++;
      end
    end
    send(32'd2, $urandom, $urandom, 1'b1, st);
    send(32'd3, $urandom, $urandom, 1'b0, st);
    wait_done();
  endtask

  task automatic test_random(input int frames);
    logic [31:0] id, h, t;
    int st;
    for (int f = 0; f < frames; f++) begin
      do_start();
      wait_collect();
      while (m_done < 4) begin
        id = ($urandom_range(0, 9) < 2) ? 32'($urandom_range(4, 40))
                                        : 32'($urandom_range(0, 3));
        h  = ($urandom_range(0, 3) == 0) ? MISS : $urandom;
        t  = $urandom;
        send(id, h, t, ($urandom_range(0, 1) == 1) && (m_done < 3), st);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      wait_done();
      checks++;
      if (rays_done !== 3'(m_done) || miss_count !== 3'(m_miss) ||
          err_dup !== m_dup || err_range !== m_rng ||
          in_ready !== 1'b0) begin
        $display("FAIL rand_frame%0d rays=%0d miss=%0d dup=%b rng=%b rdy=%b required=%0d/%0d/%b/%b/0",
                 f, rays_done, miss_count, err_dup, err_range, in_ready,
                 m_done, m_miss, m_dup, m_rng);
        failures++;
      end
      for (int a = 0; a < 4; a++) begin
        read_port(2'(a), h, t);
        checks++;
        if (h !== m_hit[a] || t !== m_tri[a]) begin
          $display("FAIL rand_rd f=%0d addr=%0d hit=%h tri=%h required=%h/%h",
                   f, a, h, t, m_hit[a], m_tri[a]);
          failures++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, t;
    int st;
    do_start();
    wait_collect();
    send(32'd2, $urandom, $urandom, 1'b0, st);
    send(32'd9, $urandom, $urandom, 1'b0, st);
    do_reset();
    @(negedge clock);
    checks++;
    if (rays_done !== 3'd0 || err_range !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL mid_reset rays=%0d rng=%b rdy=%b required=0/0/0",
               rays_done, err_range, in_ready);
      failures++;
    end
    @(posedge clock);
    #1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL mid_clear%0d in_ready=%b required=0", i, in_ready);
        failures++;
      end
    end
    checks++;
    if (rays_done !== 3'd0 || miss_count !== 3'd0 ||
        err_dup !== 1'b0 || err_range !== 1'b0) begin
      $display("FAIL mid_zero rays=%0d miss=%0d dup=%b rng=%b required=0/0/0/0",
               rays_done, miss_count, err_dup, err_range);
      failures++;
    end
    wait_collect();
    for (int i = 3; i >= 0; i--) begin
      send(32'(i), (i == 1) ? MISS : $urandom, $urandom, 1'b0, st);
    end
    wait_done();
    checks++;
    if (rays_done !== 3'd4 || miss_count !== 3'd1 ||
        err_dup !== 1'b0 || err_range !== 1'b0) begin
      $display("FAIL mid_frame rays=%0d miss=%0d dup=%b rng=%b required=4/1/0/0",
               rays_done, miss_count, err_dup, err_range);
      failures++;
    end
    for (int a = 0; a < 4; a++) begin
      read_port(2'(a), h, t);
      checks++;
      if (h !== m_hit[a] || t !== m_tri[a]) begin
        $display("FAIL mid_rd addr=%0d hit=%h tri=%h required=%h/%h",
                 a, h, t, m_hit[a], m_tri[a]);
        failures++;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_ray_id  = '0;
    in_hitT    = '0;
    in_tri_idx = '0;
    rd_addr    = '0;
    for (int i = 0; i < 4; i++) begin
      m_hit[i] = 'x;
      m_tri[i] = 'x;
      m_wr[i]  = 1'b0;
    end
    m_done = 0;
    m_miss = 0;
    m_dup  = 1'b0;
    m_rng  = 1'b0;
    test_reset();
    test_clear_timing();
    test_frame();
    test_dup_range();
    test_back_to_back();
    test_random(6);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtp_hit_collector.md
RTP_HIT_COLLECTOR -- requirements
Module: rtp_hit_collector

Interface
REQ-001 Parameter NUM_RAYS, default 1024, rays per frame; AW = clog2(NUM_RAYS).
REQ-002 Parameter FIFO_DEPTH, default 8, power of two, input buffer entries.
REQ-003 Reset is `reset`: synchronous, active-high. Clock is `clock`.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a new frame.
REQ-007 in_valid  input  1  result record valid from the traversal/intersection core.
REQ-008 in_ready  output  1  collector can accept a record.
REQ-009 in_ray_id  input  32  ray id (same encoding as io_ray_id_triangle).
REQ-010 in_hitT  input  32  IEEE-754 closest hit distance (same encoding as io_hitT).
REQ-011 in_tri_idx  input  32  hit triangle index.
REQ-012 rd_addr  input  AW  host readback address.
REQ-013 rd_hitT  output  32  stored hitT at rd_addr.
REQ-014 rd_tri_idx  output  32  stored triangle index at rd_addr.
REQ-015 rays_done  output  AW+1  distinct rays stored this frame.
REQ-016 miss_count  output  AW+1  stored rays whose hitT == 32'h7F800000 (MISS_HITT).
REQ-017 done  output  1  all NUM_RAYS rays stored.
REQ-018 err_dup  output  1  sticky; a duplicate ray id was received.
REQ-019 err_range  output  1  sticky; a ray id >= NUM_RAYS was received.

Function
REQ-020 FSM states are IDLE, CLEAR, COLLECT and DONE.
REQ-021 Transitions: IDLE --start--> CLEAR; CLEAR --last address cleared--> COLLECT; COLLECT --rays_done==NUM_RAYS--> DONE; DONE --start--> CLEAR.
REQ-022 On start in COLLECT, the FSM shall flush the FIFO and go to CLEAR; start in CLEAR shall restart the clear at address 0.
REQ-023 On entry to CLEAR, the block shall zero rays_done, miss_count, err_dup and err_range.
REQ-024 CLEAR shall clear one written-flag bit per cycle, addresses 0..NUM_RAYS-1, taking exactly NUM_RAYS cycles.
REQ-025 in_ready = (state==COLLECT) && !fifo_full; a transfer occurs when in_valid && in_ready.
REQ-026 The FIFO shall pop at most one record per cycle, whenever it is non-empty in COLLECT. Push and pop in the same cycle are permitted. Occupancy never exceeds FIFO_DEPTH.
REQ-027 Popped record with ray_id >= NUM_RAYS: set err_range, drop the record, no counter change.
REQ-028 Popped record whose written flag is set: set err_dup, drop the record (the first result is retained).
REQ-029 Any other popped record: write hitT and tri_idx at ray_id[AW-1:0], set the flag, increment rays_done, and increment miss_count if hitT == MISS_HITT.
REQ-030 A result is visible on the read port 2 cycles after the transfer at the earliest (one FIFO cycle plus one write cycle).
REQ-031 The read port shall be registered with 1-cycle latency and usable in every state. Contents are undefined for addresses whose flag is clear.
REQ-032 done shall be high exactly in DONE. The input stays stalled in DONE; counters and errors hold until the next start.
REQ-033 Counters shall not wrap: rays_done saturates at NUM_RAYS by construction (duplicates are dropped).

Reset
REQ-034 Reset shall force state IDLE, empty the FIFO, and zero in_ready, done, rays_done, miss_count, err_dup, err_range, rd_hitT and rd_tri_idx.
REQ-035 Reset mid-frame shall abandon the frame. Result RAM contents are not reset; the flags are cleared by the next CLEAR.
REQ-036 Reset has priority over start.

Structure
REQ-037 Package rtp_pkg shall hold the FSM state enum, MISS_HITT, and the result record struct {ray_id, hitT, tri_idx}.
REQ-038 Sub-module rtp_result_fifo shall be a synchronous FIFO of the record struct with full/empty outputs and a flush input.
REQ-039 Result storage shall be two NUM_RAYS x 32 inferred RAMs (hitT, tri_idx) plus a NUM_RAYS-bit flag register.

Verification (NUM_RAYS=4, FIFO_DEPTH=2)
REQ-040 Reset, start -> in_ready low for 4 cycles, then high; rays_done=0.
REQ-041 Records ids 3,0,2,1 with hitT 0x3F800000, 0x7F800000, 0x40000000, 0x3F000000 -> done high; rays_done=4; miss_count=1; rd_addr=2 gives rd_hitT=0x40000000 one cycle later.
REQ-042 id 1 sent twice, second with different hitT -> err_dup=1; rays_done increments once; first hitT read back.
REQ-043 id 7 -> err_range=1; rays_done unchanged; no RAM write.
REQ-044 in_valid held high for 3 back-to-back records -> in_ready stays high (one push and one pop per cycle, no stall); no record lost, order preserved.
REQ-045 Reset asserted after 2 records, then start -> 4 clear cycles; counters 0; errors 0; a full frame completes normally.
